// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter and its companion down counter:
// FSM state encoding, default wrap constant and a small sizing helper.
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int WRAP_DEFAULT       = 100;
  localparam int LOCK_COUNT_DEFAULT = 3;

  // Bits needed to hold a match counter saturating at lock_count (at least 1).
  function automatic int match_width(input int lock_count);
    int w;
    w = $clog2(lock_count + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/period_meter_edge_detect.sv
// Registers pulse_in once and flags its rising edge; a pulse held high
// produces a single rise.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse_in,
  output logic rise
);

  logic pulse_d;

  // NOTE: reset is synchronous -- only clk is in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) pulse_d <= 1'b0;
    else        pulse_d <= pulse_in;
  end

  // The soft clear is deliberately not wired here so the history survives it.
  assign rise = pulse_in & ~pulse_d;

endmodule

// File: rtl/period_meter.sv
// Measures the edge-to-edge interval of a periodic strobe, recovers the
// down-counter reload value, tracks lock on a stable period and counts edges.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = LOCK_COUNT_DEFAULT,
  parameter int WRAP       = WRAP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic             clear,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] reload_est,
  output logic             period_valid,
  output logic             locked,
  output logic             overflow,
  output logic [WIDTH-1:0] edge_count
);

  localparam int                 MATCH_W   = match_width(LOCK_COUNT);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_COUNT);
  localparam logic [WIDTH-1:0]   CNT_MAX   = '1;
  localparam logic [WIDTH-1:0]   WRAP_V    = WIDTH'(WRAP);

  state_t             state;
  logic               rise;
  logic [WIDTH-1:0]   cnt;
  logic [WIDTH-1:0]   prev;
  logic [MATCH_W-1:0] match;
  logic [MATCH_W-1:0] match_upd;
  logic               has_prev;

  edge_detect u_edge_detect (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (pulse_in),
    .rise     (rise)
  );

  // Match count as it will be after the current edge; decides lock entry/exit.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    match_upd = match;
    if (has_prev) begin
      if (cnt == prev) match_upd = (match == MATCH_MAX) ? MATCH_MAX : match + 1'b1;
      else             match_upd = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      reload_est   <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      overflow     <= 1'b0;
      edge_count   <= '0;
      prev         <= '0;
      match        <= '0;
      has_prev     <= 1'b0;
    end else begin
      period_valid <= 1'b0;

      if (rise)                cnt <= {{(WIDTH-1){1'b0}}, 1'b1};
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;

      // The wrap cycle swallows any edge arriving with it.
      if (edge_count == WRAP_V) edge_count <= '0;
      else if (rise)            edge_count <= edge_count + 1'b1;

      case (state)
        IDLE: begin
          if (rise) begin
            state    <= MEASURE;
            has_prev <= 1'b0;
          end
        end

        MEASURE, LOCKED: begin
          if (rise) begin
            period       <= cnt;
            reload_est   <= (cnt == '0) ? '0 : cnt - 1'b1;
            period_valid <= 1'b1;
            prev         <= cnt;
            has_prev     <= 1'b1;
            match        <= match_upd;
            if (match_upd == MATCH_MAX) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              state  <= MEASURE;
              locked <= 1'b0;
            end
          end else if (cnt == CNT_MAX) begin
            // Interval ran past the counter range: drop back to IDLE, keep period.
            overflow <= 1'b1;
            state    <= IDLE;
            locked   <= 1'b0;
            match    <= '0;
            has_prev <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Directed vector table plus randomized strobe stream for period_meter,
// checked every cycle against an interval-history reference model.
module tb_period_meter;

  localparam int WIDTH      = 8;
  localparam int LOCK_COUNT = 3;
  localparam int WRAP       = 100;
  localparam int MAX        = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pulse_in = 1'b0;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] reload_est;
  logic             period_valid;
  logic             locked;
  logic             overflow;
  logic [WIDTH-1:0] edge_count;

  period_meter #(.WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT), .WRAP(WRAP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pulse_in     (pulse_in),
    .clear        (clear),
    .period       (period),
    .reload_est   (reload_est),
    .period_valid (period_valid),
    .locked       (locked),
    .overflow     (overflow),
    .edge_count   (edge_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: remembers when the last edge happened and the recent
  // measured intervals; lock means the last LOCK_COUNT+1 intervals are equal.
  bit m_pulse_d;
  bit m_meas;
  int m_cycle;
  int m_last;
  int m_hist[$];
  int m_period;
  bit m_valid;
  bit m_locked;
  bit m_ovf;
  int m_ec;

  task automatic model_step(input bit p, input bit c, input bit r);
    bit edge_seen;
    int el;
    m_cycle++;
    if (!r || c) begin
      m_pulse_d = r ? p : 1'b0;
      m_meas    = 0;
      m_hist.delete();
      m_period  = 0;
      m_valid   = 0;
      m_locked  = 0;
      m_ovf     = 0;
      m_ec      = 0;
      return;
    end
    edge_seen = p && !m_pulse_d;
    m_pulse_d = p;
    m_valid   = 0;
    if (m_ec == WRAP) m_ec = 0;
    else if (edge_seen) m_ec++;
    if (m_meas) begin
      el = m_cycle - m_last;
      if (edge_seen) begin
        m_period = el;
        m_valid  = 1;
        m_last   = m_cycle;
        m_hist.push_back(el);
        if (m_hist.size() > LOCK_COUNT + 1) void'(m_hist.pop_front());
        m_locked = (m_hist.size() == LOCK_COUNT + 1);
        foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) m_locked = 0;
      end else if (el >= MAX) begin
        m_ovf    = 1;
        m_meas   = 0;
        m_locked = 0;
        m_hist.delete();
      end
    end else if (edge_seen) begin
      m_meas = 1;
      m_last = m_cycle;
      m_hist.delete();
    end
  endtask

  // One clock: drive inputs, step past the edge, compare against the model.
  task automatic cyc(input bit p, input bit c = 1'b0, input bit r = 1'b1);
    pulse_in = p;
    clear    = c;
    rst_n    = r;
    @(posedge clk);
    #1;
    model_step(p, c, r);
    check("model.period",       period,       m_period);
    check("model.reload_est",   reload_est,   (m_period == 0) ? 0 : m_period - 1);
    check("model.period_valid", period_valid, m_valid);
    check("model.locked",       locked,       m_locked);
    check("model.overflow",     overflow,     m_ovf);
    check("model.edge_count",   edge_count,   m_ec);
  endtask

  task automatic edge_after(input int gap);
    repeat (gap - 1) cyc(1'b0);
    cyc(1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".period"},       period,       0);
    check({tag, ".reload_est"},   reload_est,   0);
    check({tag, ".period_valid"}, period_valid, 0);
    check({tag, ".locked"},       locked,       0);
    check({tag, ".overflow"},     overflow,     0);
    check({tag, ".edge_count"},   edge_count,   0);
  endtask

  typedef struct {
    int gap;
    bit exp_valid;
    int exp_period;
    bit exp_locked;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{10,  1, 10,  0};
    vecs[1]  = '{10,  1, 10,  0};
    vecs[2]  = '{10,  1, 10,  0};
    vecs[3]  = '{10,  1, 10,  1};  // fifth edge: locked
    vecs[4]  = '{12,  1, 12,  0};  // one long interval breaks lock
    vecs[5]  = '{10,  1, 10,  0};
    vecs[6]  = '{10,  1, 10,  0};
    vecs[7]  = '{10,  1, 10,  0};
    vecs[8]  = '{10,  1, 10,  1};  // relocked
    vecs[9]  = '{MAX, 1, MAX, 0};  // longest representable interval
    vecs[10] = '{7,   1, 7,   0};

    // Reset state
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check_all_zero("reset");

    // Periodic strobe, lock, unlock, relock, max interval
    cyc(1'b0);
    cyc(1'b1);
    check("first_edge.period_valid", period_valid, 0);
    foreach (vecs[i]) begin
      edge_after(vecs[i].gap);
      check($sformatf("vec%0d.period_valid", i), period_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d.period", i),       period,       vecs[i].exp_period);
      check($sformatf("vec%0d.reload_est", i),   reload_est,   vecs[i].exp_period - 1);
      check($sformatf("vec%0d.locked", i),       locked,       vecs[i].exp_locked);
      check($sformatf("vec%0d.overflow", i),     overflow,     0);
    end

    // Silence for MAX cycles after an edge
    repeat (MAX - 1) cyc(1'b0);
    check("ovf.before", overflow, 0);
    cyc(1'b0);
    check("ovf.set",    overflow, 1);
    check("ovf.locked", locked,   0);
    check("ovf.period_holds", period, 7);
    cyc(1'b1);
    check("ovf.first_edge_valid", period_valid, 0);
    edge_after(10);
    check("ovf.relearn_valid",  period_valid, 1);
    check("ovf.relearn_period", period,       10);
    check("ovf.sticky",         overflow,     1);

    // Clear in the same cycle as an edge while locked
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1);
    repeat (4) edge_after(10);
    check("clr.locked_before", locked, 1);
    repeat (9) cyc(1'b0);
    cyc(1'b1, 1'b1);
    check_all_zero("clr");
    cyc(1'b1);
    cyc(1'b1);
    check("hold.no_edge", edge_count, 0);
    cyc(1'b0);
    cyc(1'b1);
    check("hold.one_edge", edge_count, 1);
    check("hold.idle_no_valid", period_valid, 0);

    // Edge counter wrap
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < WRAP; i++) begin
      cyc(1'b1);
      if (i < WRAP - 1) cyc(1'b0);
    end
    check("wrap.reach", edge_count, WRAP);
    cyc(1'b0);
    check("wrap.zero", edge_count, 0);
    cyc(1'b1);
    check("wrap.restart", edge_count, 1);

    // Randomized strobe segments with occasional clear/reset
    for (int seg = 0; seg < 40; seg++) begin
      int sel, g, reps, w;
      sel  = $urandom_range(0, 9);
      if (sel < 6)      g = $urandom_range(2, 12);
      else if (sel < 8) g = $urandom_range(240, 270);
      else              g = $urandom_range(13, 60);
      reps = $urandom_range(1, 8);
      w    = $urandom_range(1, (g > 3) ? 3 : g - 1);
      for (int rp = 0; rp < reps; rp++) begin
        for (int k = 0; k < g; k++) begin
          cyc(k < w, $urandom_range(0, 299) == 0, $urandom_range(0, 999) != 0);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
